// File: rtl/radio_sample_packer.sv
// Packs 1-bit I/Q samples from ANTENNAS channels into WIDTH-bit AXI-Stream packets,
// with decimation, whole-sample overflow drop and packet-aligned start/stop.
module radio_sample_packer #(
  parameter int ANTENNAS    = 24,
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 64,
  parameter int PKT_SAMPLES = 16,
  parameter int DECIMATE    = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                enable_i,
  input  logic                sample_valid_i,
  input  logic [ANTENNAS-1:0] i_data_i,
  input  logic [ANTENNAS-1:0] q_data_i,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic                m_tlast_o,
  output logic [WIDTH-1:0]    m_tdata_o,
  output logic [15:0]         drop_count_o,
  output logic                busy_o
);
  localparam int SBITS = 2*ANTENNAS;
  localparam int SW    = SBITS/WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(PKT_SAMPLES+1);
  localparam int CW    = $clog2(SW+1);
  localparam logic [AW:0]   MAX_FILL = (AW+1)'(DEPTH-SW);
  localparam logic [15:0]   DEC_LAST = 16'(DECIMATE-1);
  localparam logic [PW-1:0] PKT_LAST = PW'(PKT_SAMPLES-1);
  localparam logic [CW-1:0] SW_C     = CW'(SW);

  if (SBITS % WIDTH != 0) begin : g_bad_width
    $error("2*ANTENNAS must be a multiple of WIDTH");
  end
  if (DEPTH < 2*SW || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and >= 2*SW");
  end
  if (DECIMATE < 1 || DECIMATE > 65535 || PKT_SAMPLES < 1) begin : g_bad_cfg
    $error("DECIMATE must be 1..65535 and PKT_SAMPLES >= 1");
  end

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } word_t;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  logic [SBITS-1:0] samp;
  for (genvar n = 0; n < ANTENNAS; n++) begin : g_ant
    assign samp[2*n]   = i_data_i[n];
    assign samp[2*n+1] = q_data_i[n];
  end

  state_t           state_q, state_d;
  logic [15:0]      dec_q, dec_d;
  logic [PW-1:0]    pkt_q, pkt_d;
  logic [SBITS-1:0] stage_q, stage_d;
  logic [CW-1:0]    left_q, left_d;
  logic             last_samp_q, last_samp_d;
  logic [15:0]      drop_q, drop_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  word_t            mem [DEPTH];

  logic [AW:0] fill;
  logic        empty, ser_idle, active, candidate, accept, drop, wr_en, rd_en;
  word_t       wr_word, rd_word;

  // Free-slot check is exact: accept only happens with no writes still in flight.
  always_comb begin
    fill         = wr_ptr_q - rd_ptr_q;
    empty        = (fill == '0);
    ser_idle     = (left_q == '0);
    candidate    = active && sample_valid_i && (dec_q == '0);
    accept       = candidate && ser_idle && (fill <= MAX_FILL);
    drop         = candidate && !accept;
    wr_en        = !ser_idle;
    wr_word.data = stage_q[WIDTH-1:0];
    wr_word.last = last_samp_q && (left_q == CW'(1));
    rd_en        = !empty && m_tready_i;
    rd_word      = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (enable_i) state_d = RUN;
      RUN:      if (!enable_i)
                  state_d = (pkt_q == '0 && ser_idle && !accept) ? IDLE : STOPPING;
      STOPPING: if (enable_i)                               state_d = RUN;
                else if (wr_en && wr_word.last)             state_d = IDLE;
                else if (pkt_q == '0 && ser_idle && !accept) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q != IDLE);
    busy_o = active;
  end

  always_comb begin
    dec_d       = dec_q;
    pkt_d       = pkt_q;
    stage_d     = stage_q;
    left_d      = left_q;
    last_samp_d = last_samp_q;
    drop_d      = drop_q;
    if (state_q != RUN && state_d == RUN) dec_d = '0;
    else if (active && sample_valid_i)    dec_d = (dec_q == DEC_LAST) ? '0 : dec_q + 16'd1;
    if (accept) begin
      pkt_d       = (pkt_q == PKT_LAST) ? '0 : pkt_q + PW'(1);
      stage_d     = samp;
      left_d      = SW_C;
      last_samp_d = (pkt_q == PKT_LAST);
    end else if (!ser_idle) begin
      stage_d = stage_q >> WIDTH;
      left_d  = left_q - CW'(1);
    end
    if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dec_q       <= '0;
      pkt_q       <= '0;
      stage_q     <= '0;
      left_q      <= '0;
      last_samp_q <= 1'b0;
      drop_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      dec_q       <= dec_d;
      pkt_q       <= pkt_d;
      stage_q     <= stage_d;
      left_q      <= left_d;
      last_samp_q <= last_samp_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  // Storage is not reset, so outputs are gated by occupancy.
  assign m_tvalid_o   = !empty;
  assign m_tdata_o    = empty ? '0 : rd_word.data;
  assign m_tlast_o    = !empty && rd_word.last;
  assign drop_count_o = drop_q;
endmodule

// File: tb/tb_radio_sample_packer.sv
// Scoreboard bench: two packers (DECIMATE=1 and DECIMATE=3), DEPTH=16, 2-sample packets.
module tb_radio_sample_packer;
  localparam int ANT = 24, W = 8, DEPTH = 16, PKT = 2, SW = 6;

  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic           en_a = 0, sv_a = 0, rdy_a = 0, tv_a, tl_a, busy_a;
  logic [ANT-1:0] i_a = '0, q_a = '0;
  logic [W-1:0]   td_a;
  logic [15:0]    dc_a;
  logic           en_b = 0, sv_b = 0, rdy_b = 0, tv_b, tl_b, busy_b;
  logic [ANT-1:0] i_b = '0, q_b = '0;
  logic [W-1:0]   td_b;
  logic [15:0]    dc_b;

  radio_sample_packer #(.ANTENNAS(ANT), .WIDTH(W), .DEPTH(DEPTH), .PKT_SAMPLES(PKT), .DECIMATE(1)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .enable_i(en_a), .sample_valid_i(sv_a), .i_data_i(i_a),
    .q_data_i(q_a), .m_tvalid_o(tv_a), .m_tready_i(rdy_a), .m_tlast_o(tl_a), .m_tdata_o(td_a),
    .drop_count_o(dc_a), .busy_o(busy_a));

  radio_sample_packer #(.ANTENNAS(ANT), .WIDTH(W), .DEPTH(DEPTH), .PKT_SAMPLES(PKT), .DECIMATE(3)) u_dec (
    .aclk(aclk), .aresetn(aresetn), .enable_i(en_b), .sample_valid_i(sv_b), .i_data_i(i_b),
    .q_data_i(q_b), .m_tvalid_o(tv_b), .m_tready_i(rdy_b), .m_tlast_o(tl_b), .m_tdata_o(td_b),
    .drop_count_o(dc_b), .busy_o(busy_b));

  int checks = 0, fails = 0;
  int pkt_a = 0, pkt_b = 0, drops_a = 0;
  logic [W:0] exp_a[$], exp_b[$];
  logic [W:0] e_a, e_b;

  function automatic logic [2*ANT-1:0] pack(input logic [ANT-1:0] i, input logic [ANT-1:0] q);
    logic [2*ANT-1:0] s;
    for (int n = 0; n < ANT; n++) begin
      s[2*n]   = i[n];
      s[2*n+1] = q[n];
    end
    return s;
  endfunction

  task automatic push(input bit b, input logic [ANT-1:0] i, input logic [ANT-1:0] q);
    logic [2*ANT-1:0] s;
    s = pack(i, q);
    for (int k = 0; k < SW; k++) begin
      if (!b) exp_a.push_back({(pkt_a == PKT-1) && (k == SW-1), s[k*W +: W]});
      else    exp_b.push_back({(pkt_b == PKT-1) && (k == SW-1), s[k*W +: W]});
    end
    if (!b) pkt_a = (pkt_a + 1) % PKT;
    else    pkt_b = (pkt_b + 1) % PKT;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Callers sit at posedge+1; the strobe is captured on the next edge.
  task automatic strobe(input bit b, input logic [ANT-1:0] i, input logic [ANT-1:0] q);
    if (!b) begin i_a = i; q_a = q; sv_a = 1; end
    else    begin i_b = i; q_b = q; sv_b = 1; end
    cyc(1);
    sv_a = 0;
    sv_b = 0;
  endtask

  task automatic drain(input bit b, input string name);
    for (int i = 0; i < 400 && (b ? exp_b.size() : exp_a.size()) != 0; i++) cyc(1);
    checks++;
    if ((b ? exp_b.size() : exp_a.size()) != 0) begin
      fails++;
      $display("FAIL %s_drain words_left=%0d required=0", name, b ? exp_b.size() : exp_a.size());
    end
    cyc(3);
    checks++;
    if ((b ? tv_b : tv_a) !== 1'b0) begin
      fails++;
      $display("FAIL %s_extra_words tvalid=%b required=0", name, b ? tv_b : tv_a);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn && tv_a && rdy_a) begin
      checks++;
      if (exp_a.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected_word got last=%b data=%h required=none", tl_a, td_a);
      end else begin
        e_a = exp_a.pop_front();
        if ({tl_a, td_a} !== e_a) begin
          fails++;
          $display("FAIL a_word got last=%b data=%h required last=%b data=%h", tl_a, td_a, e_a[W], e_a[W-1:0]);
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (aresetn && tv_b && rdy_b) begin
      checks++;
      if (exp_b.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected_word got last=%b data=%h required=none", tl_b, td_b);
      end else begin
        e_b = exp_b.pop_front();
        if ({tl_b, td_b} !== e_b) begin
          fails++;
          $display("FAIL b_word got last=%b data=%h required last=%b data=%h", tl_b, td_b, e_b[W], e_b[W-1:0]);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (tv_a !== 1'b0)   begin fails++; $display("FAIL reset_tvalid got %b required 0", tv_a); end
    checks++; if (tl_a !== 1'b0)   begin fails++; $display("FAIL reset_tlast got %b required 0", tl_a); end
    checks++; if (td_a !== '0)     begin fails++; $display("FAIL reset_tdata got %h required 00", td_a); end
    checks++; if (dc_a !== 16'd0)  begin fails++; $display("FAIL reset_drops got %0d required 0", dc_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b required 0", busy_a); end
    aresetn = 1;
    cyc(2);
  endtask

  task automatic test_basic();
    logic [ANT-1:0] ri, rq;
    rdy_a = 1;
    en_a  = 1;
    cyc(2);
    checks++; if (busy_a !== 1'b1) begin fails++; $display("FAIL basic_busy got %b required 1", busy_a); end
    push(0, 24'h000001, 24'h000000);
    strobe(0, 24'h000001, 24'h000000);
    checks++; if (tv_a !== 1'b0) begin fails++; $display("FAIL basic_latency_t1 tvalid=%b required 0", tv_a); end
    cyc(1);
    checks++; if (tv_a !== 1'b1) begin fails++; $display("FAIL basic_latency_t2 tvalid=%b required 1", tv_a); end
    cyc(6);
    ri = 24'($urandom); rq = 24'($urandom);
    push(0, ri, rq);
    strobe(0, ri, rq);
    drain(0, "basic");
  endtask

  task automatic test_random_packets();
    logic [ANT-1:0] ri, rq;
    for (int s = 0; s < 6; s++) begin
      ri = 24'($urandom); rq = 24'($urandom);
      push(0, ri, rq);
      strobe(0, ri, rq);
      cyc(7);
    end
    drain(0, "random");
  endtask

  task automatic test_overflow();
    logic [ANT-1:0] ri, rq;
    rdy_a = 0;
    for (int s = 0; s < 5; s++) begin
      ri = 24'($urandom); rq = 24'($urandom);
      if (s < 2) push(0, ri, rq);
      else       drops_a++;
      strobe(0, ri, rq);
      cyc(7);
    end
    checks++;
    if (dc_a !== 16'(drops_a)) begin fails++; $display("FAIL overflow_drops got %0d required %0d", dc_a, drops_a); end
    cyc(4);
    checks++;
    if (tv_a !== 1'b1 || {tl_a, td_a} !== exp_a[0]) begin
      fails++;
      $display("FAIL overflow_stall_hold got v=%b last=%b data=%h required v=1 %h", tv_a, tl_a, td_a, exp_a[0]);
    end
    rdy_a = 1;
    drain(0, "overflow");
  endtask

  task automatic test_stop_mid_packet();
    logic [ANT-1:0] ri, rq;
    ri = 24'($urandom); rq = 24'($urandom);
    push(0, ri, rq);
    strobe(0, ri, rq);
    en_a = 0;
    cyc(2);
    checks++; if (busy_a !== 1'b1) begin fails++; $display("FAIL stop_stopping_busy got %b required 1", busy_a); end
    cyc(5);
    ri = 24'($urandom); rq = 24'($urandom);
    push(0, ri, rq);
    strobe(0, ri, rq);
    cyc(10);
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL stop_idle_busy got %b required 0", busy_a); end
    strobe(0, 24'hFFFFFF, 24'hFFFFFF);
    drain(0, "stop");
    checks++;
    if (dc_a !== 16'(drops_a)) begin fails++; $display("FAIL stop_idle_drops got %0d required %0d", dc_a, drops_a); end
  endtask

  task automatic test_decimate();
    logic [ANT-1:0] ri, rq;
    rdy_b = 1;
    en_b  = 1;
    cyc(2);
    for (int s = 0; s < 9; s++) begin
      ri = 24'($urandom); rq = 24'($urandom);
      if (s % 3 == 0) push(1, ri, rq);
      strobe(1, ri, rq);
      cyc(9);
    end
    drain(1, "decimate");
    checks++; if (dc_b !== 16'd0) begin fails++; $display("FAIL decimate_drops got %0d required 0", dc_b); end
  endtask

  task automatic test_reset_mid_packet();
    logic [ANT-1:0] ri, rq;
    en_a  = 1;
    cyc(2);
    rdy_a = 0;
    strobe(0, 24'h123456, 24'h654321);
    cyc(4);
    checks++; if (dc_a !== 16'(drops_a)) begin fails++; $display("FAIL rstmid_pre_drops got %0d required %0d", dc_a, drops_a); end
    aresetn = 0;
    en_b = 0;
    exp_a.delete();
    exp_b.delete();
    pkt_a = 0;
    pkt_b = 0;
    drops_a = 0;
    cyc(1);
    checks++; if (tv_a !== 1'b0)   begin fails++; $display("FAIL rstmid_tvalid got %b required 0", tv_a); end
    checks++; if (td_a !== '0)     begin fails++; $display("FAIL rstmid_tdata got %h required 00", td_a); end
    checks++; if (dc_a !== 16'd0)  begin fails++; $display("FAIL rstmid_drops got %0d required 0", dc_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b required 0", busy_a); end
    aresetn = 1;
    rdy_a   = 1;
    cyc(3);
    for (int s = 0; s < 2; s++) begin
      ri = 24'($urandom); rq = 24'($urandom);
      push(0, ri, rq);
      strobe(0, ri, rq);
      cyc(7);
    end
    drain(0, "rstmid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_packets();
    test_overflow();
    test_stop_mid_packet();
    test_decimate();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
